// File: rtl/md_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_MULT  = 2'd1,
        MD_DIVU  = 2'd2,
        MD_DIV   = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // The opcode encoding packs "divide" into bit 1 and "signed" into bit 0.
    function automatic logic op_is_div(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_is_div,
    output logic [WIDTH-1:0]   o_next_hi,
    output logic [WIDTH-1:0]   o_next_lo
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_partial;
    logic             w_ge;

    assign w_hi = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo = i_acc[WIDTH-1:0];

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // keeping the carry so the right shift does not lose it.
    assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_operand} : '0);

    // Divide: the remainder stays below the divisor, so the shifted partial
    // remainder needs exactly one extra bit.
    assign w_partial = {w_hi, w_lo[WIDTH-1]};
    assign w_ge      = (w_partial >= {1'b0, i_operand});

    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_next_hi = w_sum[WIDTH:1];
        o_next_lo = {w_sum[0], w_lo[WIDTH-1:1]};
        if (i_is_div) begin
            o_next_hi = w_ge ? (w_partial[WIDTH-1:0] - i_operand) : w_partial[WIDTH-1:0];
            o_next_lo = {w_lo[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Parametrised iterative multiply/divide unit with a Start/Busy/Done handshake.
// Results land in Hi/Lo WIDTH+2 cycles after Start (1 cycle for divide-by-zero).
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    md_op_t             w_op;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_start_dz;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_op       = md_op_t'(i_op);
    assign w_sign_a   = op_is_signed(w_op) & i_a[WIDTH-1];
    assign w_sign_b   = op_is_signed(w_op) & i_b[WIDTH-1];
    assign w_mag_a    = w_sign_a ? -i_a : i_a;
    assign w_mag_b    = w_sign_b ? -i_b : i_b;
    assign w_start_dz = op_is_div(w_op) && (i_b == '0);

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_neg = -w_prod;

    // The dividend/multiplier magnitude lives in the low half; the divisor or
    // multiplicand magnitude is held in r_opnd for the whole run.
    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     ({r_acc_hi, r_acc_lo}),
        .i_operand (r_opnd),
        .i_is_div  (r_is_div),
        .o_next_hi (w_next_hi),
        .o_next_lo (w_next_lo)
    );

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_is_div <= op_is_div(w_op);
                        r_opnd   <= w_mag_b;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_mag_a;
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_dz     <= w_start_dz;
                        if (w_start_dz) begin
                            r_state <= MD_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(WIDTH);
                            r_state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    // Quotient sign is signA^signB; remainder follows the dividend.
                    if (r_is_div) begin
                        r_lo <= r_neg_q ? -r_acc_lo : r_acc_lo;
                        r_hi <= r_neg_r ? -r_acc_hi : r_acc_hi;
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
                    end
                    r_state <= MD_DONE;
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != MD_IDLE);
    assign o_done     = (r_state == MD_DONE);
    assign o_div_zero = o_done & r_dz;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32, 16 and 8: directed vectors,
// handshake corner cases, and a native-arithmetic reference for the narrow widths.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start8, start16, start32;

    logic        busy8, done8, dz8;
    logic        busy16, done16, dz16;
    logic        busy32, done32, dz32;
    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    logic [31:0] hi32, lo32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_reset(rst), .i_start(start32), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy32), .o_done(done32), .o_div_zero(dz32), .o_hi(hi32), .o_lo(lo32)
    );

    mult_div_unit #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(start16), .i_op(op), .i_a(a[15:0]), .i_b(b[15:0]),
        .o_busy(busy16), .o_done(done16), .o_div_zero(dz16), .o_hi(hi16), .o_lo(lo16)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_start(start8), .i_op(op), .i_a(a[7:0]), .i_b(b[7:0]),
        .o_busy(busy8), .o_done(done8), .o_div_zero(dz8), .o_hi(hi8), .o_lo(lo8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            8:       start8  = v;
            16:      start16 = v;
            default: start32 = v;
        endcase
    endtask

    task automatic sample(input int w, output logic bsy, output logic dn, output logic dz,
                          output logic [31:0] h, output logic [31:0] l);
        case (w)
            8: begin
                bsy = busy8; dn = done8; dz = dz8; h = {24'd0, hi8}; l = {24'd0, lo8};
            end
            16: begin
                bsy = busy16; dn = done16; dz = dz16; h = {16'd0, hi16}; l = {16'd0, lo16};
            end
            default: begin
                bsy = busy32; dn = done32; dz = dz32; h = hi32; l = lo32;
            end
        endcase
    endtask

    // Independent reference using native 64-bit arithmetic (truncating division).
    task automatic ref_md(input int w, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] mask, twow, ua, ub, t;
        longint      sa, sb, sq, sr;
        twow = 64'd1 << w;
        mask = twow - 64'd1;
        ua   = {32'd0, ia} & mask;
        ub   = {32'd0, ib} & mask;
        sa   = ia[w-1] ? longint'(ua) - longint'(twow) : longint'(ua);
        sb   = ib[w-1] ? longint'(ub) - longint'(twow) : longint'(ub);
        rh   = '0;
        rl   = '0;
        case (o)
            2'd0: begin
                t  = ua * ub;
                rh = 32'((t >> w) & mask);
                rl = 32'(t & mask);
            end
            2'd1: begin
                t  = sa * sb;
                rh = 32'((t >> w) & mask);
                rl = 32'(t & mask);
            end
            2'd2: begin
                rl = 32'(ua / ub);
                rh = 32'(ua % ub);
            end
            default: begin
                sq = sa / sb;
                sr = sa % sb;
                t  = sq;
                rl = 32'(t & mask);
                t  = sr;
                rh = 32'(t & mask);
            end
        endcase
    endtask

    // Issue one operation and check the handshake timing and the results.
    task automatic run_op(input int w, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input string name);
        int          elat, cyc, busy_cnt;
        logic        bsy, dn, dz;
        logic [31:0] h, l;
        elat = edz ? 1 : w + 2;
        @(negedge clk);
        op = o; a = ia; b = ib;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        cyc      = 1;
        busy_cnt = 0;
        sample(w, bsy, dn, dz, h, l);
        while (!dn && cyc < 100) begin
            if (bsy) busy_cnt++;
            @(negedge clk);
            cyc++;
            sample(w, bsy, dn, dz, h, l);
        end
        if (bsy) busy_cnt++;
        check({name, " done seen"}, 64'(dn), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'(elat));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(elat));
        check({name, " divzero"}, 64'(dz), 64'(edz));
        check({name, " hi"}, 64'(h), 64'(eh));
        check({name, " lo"}, 64'(l), 64'(el));
        @(negedge clk);
        sample(w, bsy, dn, dz, h, l);
        check({name, " back to idle"}, {61'd0, bsy, dn, dz}, 64'd0);
    endtask

    initial begin
        int          cyc, ndone;
        logic [31:0] eh, el, mask, mn;
        logic [31:0] pa[5];
        logic [31:0] pb[5];

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg"};
        vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg"};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7"};
        vecs[4]  = '{2'd2, 32'd100,      32'd0,        32'd2,        32'd14,       1'b1, "divu_zero"};
        vecs[5]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"};
        vecs[6]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minmin"};
        vecs[7]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_pos_neg"};
        vecs[8]  = '{2'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, "div_neg_neg"};
        vecs[9]  = '{2'd3, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000003, 1'b1, "div_zero"};
        vecs[10] = '{2'd0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0, "multu_by_0"};
        vecs[11] = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_by_1"};

        rst = 1'b1; op = '0; a = '0; b = '0;
        start8 = 1'b0; start16 = 1'b0; start32 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset flags32", {61'd0, busy32, done32, dz32}, 64'd0);
        check("reset hilo32", {hi32, lo32}, 64'd0);
        check("reset flags narrow", {58'd0, busy8, done8, dz8, busy16, done16, dz16}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(32, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].dz, vecs[i].name);
        end

        // Start while busy (a would-be divide-by-zero) must be ignored.
        @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd5; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        op = 2'd3; a = 32'h0000FFFF; b = 32'd0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc++;
        while (!done32 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_start latency", 64'(cyc), 64'd34);
        check("busy_start divzero", 64'(dz32), 64'd0);
        check("busy_start hi", 64'(hi32), 64'd0);
        check("busy_start lo", 64'(lo32), 64'd15);
        // Start during the DONE cycle is ignored too.
        op = 2'd0; a = 32'd1; b = 32'd1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check("done_start ignored", 64'(busy32), 64'd0);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        op = 2'd0; a = 32'hFFFFFFFF; b = 32'd2; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", 64'(busy32), 64'd0);
        check("midreset hilo", {hi32, lo32}, 64'd0);
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("midreset no done", 64'(ndone), 64'd0);
        run_op(32, 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "after_reset");

        // Narrow widths against the reference model.
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w    = (wi == 0) ? 8 : 16;
            mask = (32'd1 << w) - 32'd1;
            mn   = 32'd1 << (w - 1);
            pa[0] = mask;        pb[0] = mask;
            pa[1] = mn;          pb[1] = mask;
            pa[2] = 32'd100;     pb[2] = 32'd7;
            pa[3] = mask - 32'd6; pb[3] = 32'd2;
            pa[4] = mn;          pb[4] = mn;
            eh = '0;
            el = '0;
            for (int p = 0; p < 5; p++) begin
                for (int o = 0; o < 4; o++) begin
                    ref_md(w, 2'(o), pa[p], pb[p], eh, el);
                    run_op(w, 2'(o), pa[p], pb[p], eh, el, 1'b0,
                           $sformatf("w%0d op%0d pair%0d", w, o, p));
                end
            end
            run_op(w, 2'd2, 32'd5, 32'd0, eh, el, 1'b1, $sformatf("w%0d divzero", w));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
